spi_cs_sequencer: RTL and testbench

Shares one `spi_master` byte engine between `NUM_REQ` requesters.
- Arbitrates round-robin and drives the master's `start_transfer`/`tx_data_reg`.
- Generates one active-low chip select per requester, with programmable setup, hold and inter-frame gap.
- Keeps a grant locked for multi-byte frames until the requester flags the last byte.
- Sits between the application logic and `spi_master`; `spi_clk`/`spi_mosi` pass straight from the master to pins.

---
 rtl/spi_seq_pkg.sv | 44 ++++
 rtl/spi_cs_sequencer_rr_arbiter.sv | 42 ++++
 rtl/spi_cs_sequencer.sv | 164 ++++++++++++++++
 tb/tb_spi_cs_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_seq_pkg
// Description : Shared constants, state encoding and helpers for the SPI
//               chip-select sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_seq_pkg;

  localparam int C_BYTE_W  = 8;
  localparam int C_STATE_W = 3;

  localparam logic [C_STATE_W-1:0] C_ST_RST_WAIT  = 3'd0;
  localparam logic [C_STATE_W-1:0] C_ST_IDLE      = 3'd1;
  localparam logic [C_STATE_W-1:0] C_ST_SETUP     = 3'd2;
  localparam logic [C_STATE_W-1:0] C_ST_START     = 3'd3;
  localparam logic [C_STATE_W-1:0] C_ST_WAIT_DONE = 3'd4;
  localparam logic [C_STATE_W-1:0] C_ST_NEXT      = 3'd5;
  localparam logic [C_STATE_W-1:0] C_ST_HOLD      = 3'd6;
  localparam logic [C_STATE_W-1:0] C_ST_GAP       = 3'd7;

  typedef enum logic [C_STATE_W-1:0] {
    S_RST_WAIT  = C_ST_RST_WAIT,
    S_IDLE      = C_ST_IDLE,
    S_SETUP     = C_ST_SETUP,
    S_START     = C_ST_START,
    S_WAIT_DONE = C_ST_WAIT_DONE,
    S_NEXT      = C_ST_NEXT,
    S_HOLD      = C_ST_HOLD,
    S_GAP       = C_ST_GAP
  } state_t;

  // Largest of four cycle counts; sizes the shared state counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cs_sequencer_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Scans from last_grant+1 with
//               wrap-around and returns the first valid requester.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // Index 'off' positions after 'base', modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum -= NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // First valid requester after the previous winner wins; lowest offset has priority.
  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_valid && valid[wrap_idx(last_grant, k)]) begin
        grant_valid = 1'b1;
        grant_idx   = wrap_idx(last_grant, k);
      end
    end
    grant_oh[grant_idx] = grant_valid;
  end

endmodule
`default_nettype wire

// File: rtl/spi_cs_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_cs_sequencer
// Description : Shares one SPI byte engine between NUM_REQ requesters with
//               round-robin arbitration, per-requester active-low chip
//               selects and programmable CS setup / hold / inter-frame gap.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cs_sequencer
  import spi_seq_pkg::*;
#(
  parameter int NUM_REQ           = 2,
  parameter int CS_SETUP_CYCLES   = 4,
  parameter int CS_HOLD_CYCLES    = 4,
  parameter int CS_GAP_CYCLES     = 8,
  parameter int RESET_WAIT_CYCLES = 32768
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [C_BYTE_W*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [C_BYTE_W-1:0]          spi_tx_data,
  output logic                         spi_start,
  input  logic                         spi_done,
  output logic [NUM_REQ-1:0]           spi_cs_n,
  output logic                         busy
);

  localparam int C_IDX_W = $clog2(NUM_REQ);
  localparam int C_CNT_W = $clog2(max4(CS_SETUP_CYCLES, CS_HOLD_CYCLES,
                                       CS_GAP_CYCLES, RESET_WAIT_CYCLES) + 1);

  localparam logic [C_CNT_W-1:0] C_SETUP_LAST = C_CNT_W'(CS_SETUP_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_HOLD_LAST  = C_CNT_W'(CS_HOLD_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_GAP_LAST   = C_CNT_W'(CS_GAP_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_RST_LAST   = C_CNT_W'(RESET_WAIT_CYCLES - 1);
  localparam logic [C_IDX_W-1:0] C_LAST_REQ   = C_IDX_W'(NUM_REQ - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [C_CNT_W-1:0]    r_cnt;
  logic [C_IDX_W-1:0]    r_grant;
  logic [C_IDX_W-1:0]    w_grant_nxt;
  logic [C_IDX_W-1:0]    r_last_grant;
  logic                  r_last;
  logic [C_BYTE_W-1:0]   r_tx_data;
  logic [NUM_REQ-1:0]    r_cs_n;
  logic [NUM_REQ-1:0]    w_cs_n_nxt;
  logic                  r_start;
  logic                  w_accept;
  logic [NUM_REQ-1:0]    w_ready;
  logic [C_BYTE_W-1:0]   w_sel_data;
  logic                  w_sel_last;
  logic [NUM_REQ-1:0]    w_arb_oh;
  logic [C_IDX_W-1:0]    w_arb_idx;
  logic                  w_arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (C_IDX_W)
  ) u_arb (
    .valid       (req_valid),
    .last_grant  (r_last_grant),
    .grant_oh    (w_arb_oh),
    .grant_idx   (w_arb_idx),
    .grant_valid (w_arb_any)
  );

  // State register; the counter restarts from zero on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RST_WAIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
    end
  end

  // Next-state, accept strobe and ready vector; spi_done only matters in RST_WAIT/WAIT_DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_accept    = 1'b0;
    w_ready     = '0;
    case (r_state)
      S_RST_WAIT:  if (spi_done || r_cnt == C_RST_LAST) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (w_arb_any) begin
          w_ready     = w_arb_oh;
          w_accept    = 1'b1;
          w_grant_nxt = w_arb_idx;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP:     if (r_cnt == C_SETUP_LAST) w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (spi_done) w_state_nxt = r_last ? S_HOLD : S_NEXT;
      S_NEXT: begin
        // Locked grant: only the current owner may supply the next byte.
        if (req_valid[r_grant]) begin
          w_ready[r_grant] = 1'b1;
          w_accept         = 1'b1;
          w_state_nxt      = S_START;
        end
      end
      S_HOLD:      if (r_cnt == C_HOLD_LAST) w_state_nxt = S_GAP;
      S_GAP:       if (r_cnt == C_GAP_LAST) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_RST_WAIT;
    endcase
  end

  // Chip select for the cycle after this edge: low for the owner from SETUP through HOLD.
  always_comb begin
    w_cs_n_nxt = '1;
    case (w_state_nxt)
      S_SETUP, S_START, S_WAIT_DONE, S_NEXT, S_HOLD: w_cs_n_nxt[w_grant_nxt] = 1'b0;
      default: ;
    endcase
  end

  // Byte and last flag of the requester being accepted this cycle.
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (C_IDX_W'(i) == w_grant_nxt) begin
        w_sel_data = req_data[i*C_BYTE_W +: C_BYTE_W];
        w_sel_last = req_last[i];
      end
    end
  end

  // Registered pin outputs and datapath; tx data only moves on accept so it is stable mid-byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= '0;
      r_last_grant <= C_LAST_REQ;
      r_last       <= 1'b0;
      r_tx_data    <= '0;
      r_cs_n       <= '1;
      r_start      <= 1'b0;
    end else begin
      r_grant <= w_grant_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_start <= (w_state_nxt == S_START);
      if (w_accept) begin
        r_tx_data <= w_sel_data;
        r_last    <= w_sel_last;
      end
      if (r_state == S_GAP && w_state_nxt == S_IDLE) r_last_grant <= r_grant;
    end
  end

  assign req_ready   = w_ready;
  assign spi_tx_data = r_tx_data;
  assign spi_start   = r_start;
  assign spi_cs_n    = r_cs_n;
  assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_cs_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_cs_sequencer
// Description : Directed self-checking bench for spi_cs_sequencer with a
//               simple byte-engine model that answers spi_start with done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cs_sequencer;

  localparam int NUM_REQ = 2;
  localparam int C_MBYTE = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  spi_tx_data;
  logic        spi_start;
  logic        spi_done;
  logic [1:0]  spi_cs_n;
  logic        busy;

  logic        m_active   = 1'b0;
  logic        m_done     = 1'b0;
  logic        force_done = 1'b0;
  int          m_cnt      = 0;
  logic [7:0]  mosi_q[$];

  int          n_pass     = 0;
  int          n_total    = 0;
  int          multi_low  = 0;
  logic [1:0]  g [4];

  always #5 clk = ~clk;

  spi_cs_sequencer #(
    .NUM_REQ           (NUM_REQ),
    .CS_SETUP_CYCLES   (4),
    .CS_HOLD_CYCLES    (4),
    .CS_GAP_CYCLES     (8),
    .RESET_WAIT_CYCLES (32768)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .spi_tx_data (spi_tx_data),
    .spi_start   (spi_start),
    .spi_done    (spi_done),
    .spi_cs_n    (spi_cs_n),
    .busy        (busy)
  );

  assign spi_done = m_done | force_done;

  // Byte engine model: not reset by rst, samples tx data mid-byte like the real master.
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (m_active) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 8) mosi_q.push_back(spi_tx_data);
      if (m_cnt == C_MBYTE - 1) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end
    end else if (spi_start) begin
      m_active <= 1'b1;
      m_cnt    <= 0;
    end
  end

  // More than one chip select low at once is always wrong.
  always @(negedge clk) begin
    if ($countones(~spi_cs_n) > 1) multi_low <= multi_low + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] next_mosi();
    if (mosi_q.size() == 0) return 32'hFFFF_FFFF;
    return {24'h0, mosi_q.pop_front()};
  endfunction

  initial begin
    int   n;
    logic ok;
    int   gcount;

    // ---------------- reset values and full quiet time ----------------
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n",  32'(spi_cs_n),    32'h3);
    chk("rst_start", 32'(spi_start),   32'h0);
    chk("rst_tx",    32'(spi_tx_data), 32'h0);
    chk("rst_ready", 32'(req_ready),   32'h0);
    chk("rst_busy",  32'(busy),        32'h1);
    rst = 1'b0;
    n = 0;
    while (busy && n < 40000) begin n++; @(negedge clk); end
    chk("rst_wait_len", 32'(n), 32'd32768);

    // ---------------- reset again, early exit on spi_done ----------------
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("busy_c100", 32'(busy), 32'h1);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    chk("idle_c101", 32'(busy), 32'h0);

    // ---------------- req0 single byte 0xA5 ----------------
    req_valid = 2'b01; req_data = 16'h00A5; req_last = 2'b01;
    #1;
    chk("idle_ready_r0", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    chk("cs0_low_T1", 32'(spi_cs_n),    32'h2);
    chk("tx_a5",      32'(spi_tx_data), 32'hA5);
    repeat (3) @(negedge clk);
    chk("no_start_T4", 32'(spi_start), 32'h0);
    @(negedge clk);
    chk("start_T5", 32'(spi_start), 32'h1);
    n = 0; ok = 1'b1;
    while (!spi_done && n < 200) begin
      if (spi_tx_data !== 8'hA5) ok = 1'b0;
      n++; @(negedge clk);
    end
    chk("done_a5",     32'(spi_done), 32'h1);
    chk("tx_stable_a", 32'(ok),       32'h1);
    repeat (4) @(negedge clk);
    chk("cs_hold_last", 32'(spi_cs_n), 32'h2);
    @(negedge clk);
    chk("cs_rise_D5", 32'(spi_cs_n), 32'h3);
    repeat (7) @(negedge clk);
    chk("busy_gap_end", 32'(busy), 32'h1);
    @(negedge clk);
    chk("idle_after_gap", 32'(busy), 32'h0);
    chk("mosi_a5", next_mosi(), 32'hA5);

    // ---------------- req1 3-byte frame, req0 waiting ----------------
    req_valid = 2'b11; req_data = 16'h11B6; req_last = 2'b01;
    #1;
    chk("rr_pick_r1", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_data[15:8] = 8'h22;
    chk("cs1_low", 32'(spi_cs_n), 32'h1);
    ok = 1'b1;
    for (int b = 0; b < 2; b++) begin
      n = 0;
      while (!spi_done && n < 200) begin
        if (spi_cs_n !== 2'b01) ok = 1'b0;
        n++; @(negedge clk);
      end
      chk("frame_done", 32'(spi_done), 32'h1);
      @(negedge clk);
      chk("next_ready_r1", 32'(req_ready), 32'h2);
      chk("next_cs1_low",  32'(spi_cs_n),  32'h1);
      @(negedge clk);
      chk("next_start", 32'(spi_start), 32'h1);
      chk("next_tx",    32'(spi_tx_data), (b == 0) ? 32'h22 : 32'h33);
      if (b == 0) begin
        req_data[15:8] = 8'h33; req_last = 2'b11;
      end else begin
        req_valid[1] = 1'b0;
      end
    end
    n = 0;
    while (!spi_done && n < 200) begin
      if (spi_cs_n !== 2'b01) ok = 1'b0;
      n++; @(negedge clk);
    end
    chk("cs1_locked", 32'(ok), 32'h1);
    n = 0;
    while (spi_cs_n !== 2'b11 && n < 50) begin n++; @(negedge clk); end
    chk("cs1_hold_len", 32'(n), 32'd5);
    n = 0;
    while (!req_ready[0] && n < 100) begin n++; @(negedge clk); end
    chk("gap_before_r0", 32'(n), 32'd8);
    @(negedge clk);
    req_valid = 2'b00;
    chk("cs0_after_gap", 32'(spi_cs_n), 32'h2);
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    chk("frame2_idle", 32'(busy), 32'h0);
    chk("mosi_11", next_mosi(), 32'h11);
    chk("mosi_22", next_mosi(), 32'h22);
    chk("mosi_33", next_mosi(), 32'h33);
    chk("mosi_b6", next_mosi(), 32'hB6);

    // ---------------- fresh reset, both requesters continuously valid ----------------
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    req_valid = 2'b11; req_last = 2'b11; req_data = 16'hC33C;
    gcount = 0; n = 0;
    while (gcount < 4 && n < 1000) begin
      #1;
      if ((req_valid & req_ready) != 2'b00) begin
        g[gcount] = req_ready;
        gcount++;
      end
      n++;
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("grant_count", 32'(gcount), 32'd4);
    chk("grant0", 32'(g[0]), 32'h1);
    chk("grant1", 32'(g[1]), 32'h2);
    chk("grant2", 32'(g[2]), 32'h1);
    chk("grant3", 32'(g[3]), 32'h2);
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    chk("alt_idle", 32'(busy), 32'h0);
    mosi_q.delete();

    // ---------------- req0 stalls in NEXT, then resumes ----------------
    req_valid = 2'b01; req_data = 16'h003C; req_last = 2'b00;
    @(negedge clk);
    req_valid = 2'b00;
    n = 0;
    while (!spi_done && n < 200) begin n++; @(negedge clk); end
    chk("done_3c", 32'(spi_done), 32'h1);
    @(negedge clk);
    ok = 1'b1;
    repeat (50) begin
      if (spi_cs_n !== 2'b10 || spi_start !== 1'b0 || req_ready !== 2'b00) ok = 1'b0;
      @(negedge clk);
    end
    chk("stall_cs_low_no_start", 32'(ok), 32'h1);
    req_valid = 2'b01; req_data = 16'h007E; req_last = 2'b01;
    #1;
    chk("resume_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    chk("resume_start", 32'(spi_start),   32'h1);
    chk("resume_tx",    32'(spi_tx_data), 32'h7E);
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    chk("resume_idle", 32'(busy), 32'h0);
    chk("mosi_3c", next_mosi(), 32'h3C);
    chk("mosi_7e", next_mosi(), 32'h7E);

    // ---------------- reset during WAIT_DONE ----------------
    req_valid = 2'b10; req_data = 16'h5A00; req_last = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    n = 0;
    while (!spi_start && n < 50) begin n++; @(negedge clk); end
    chk("start_5a", 32'(spi_start), 32'h1);
    repeat (12) @(negedge clk);
    chk("pre_rst_cs1", 32'(spi_cs_n), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_cs_high", 32'(spi_cs_n), 32'h3);
    chk("midrst_busy",    32'(busy),     32'h1);
    ok = 1'b1; n = 0;
    while (busy && n < 200) begin
      if (spi_start !== 1'b0 || spi_cs_n !== 2'b11) ok = 1'b0;
      n++; @(negedge clk);
    end
    chk("rst_wait_quiet", 32'(ok), 32'h1);
    chk("old_done_exit",  32'(n),  32'd5);
    chk("mosi_5a", next_mosi(), 32'h5A);
    req_valid = 2'b01; req_data = 16'h0099; req_last = 2'b01;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    chk("post_rst_cs0", 32'(spi_cs_n), 32'h2);
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    chk("post_rst_idle", 32'(busy), 32'h0);
    chk("mosi_99", next_mosi(), 32'h99);
    chk("mosi_empty", 32'(mosi_q.size()), 32'd0);
    chk("one_cs_low_max", 32'(multi_low), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
